ffre_ena_sched: RTL and testbench

//  Round-robin scheduler that shares the bank's enable/clear lines among NREQ

---
 rtl/ffre_ena_sched.sv | 206 ++++++++++++++++++++
 tb/tb_ffre_ena_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffre_ena_sched.sv
// ffre_ena_sched: round-robin scheduler for the enable/clear lines of a dffre register bank.
// One register group is granted at a time. It gets an optional one-cycle synchronous clear,
// then exactly BURST cycles of load enable, then GAP idle cycles before re-arbitration.
// Build option: define FFRE_SCHED_PRIO_EN to add a 'prio' input. A group whose req and
// prio bits are both set wins ahead of round robin, with the lowest such index chosen;
// a priority grant leaves the round-robin pointer untouched.
//
// Handshake: req/clr_req are levels sampled only while the FSM is idle. A grant is
// announced one cycle later on gnt and held until the burst ends. done pulses for one
// cycle after the last enable cycle. Requests cannot be withdrawn mid-burst; changes to
// req/clr_req outside IDLE are ignored.
//
// Vector ports use [0:NREQ-1] ordering, so bit i of every vector belongs to group i.
module ffre_ena_sched #(
    parameter int NREQ  = 5,
    parameter int BURST = 4,
    parameter int GAP   = 1,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [0:NREQ-1] req,
    input  logic [0:NREQ-1] clr_req,
`ifdef FFRE_SCHED_PRIO_EN
    input  logic [0:NREQ-1] prio,
`endif
    output logic [0:NREQ-1] gnt,
    output logic [0:NREQ-1] ena,
    output logic [0:NREQ-1] grp_clr,
    output logic [0:NREQ-1] done,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    // Pointer/winner width; a single requester still needs one bit.
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    // A burst length of 0 behaves like 1 so every grant produces at least one enable.
    localparam int BURST_EFF = (BURST < 1) ? 1 : BURST;
    localparam logic [CW-1:0] BURST_LD = CW'(BURST_EFF - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]   rr_win;
    logic            rr_hit;
    logic [PW-1:0]   pr_win;
    logic            pr_hit;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_nxt;
    logic [PW:0]     scan;

    assign dbg_state = state;

    // One-hot decode of a group index.
    function automatic logic [0:NREQ-1] onehot(input logic [PW-1:0] idx);
        logic [0:NREQ-1] o;
        o      = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

    // Round-robin search: first set req at or after ptr, wrapping at NREQ.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = '0;
        scan   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + PW1'(k);
            if (scan >= PW1'(NREQ)) begin
                scan = scan - PW1'(NREQ);
            end
            if (!rr_hit && req[scan[PW-1:0]]) begin
                rr_hit = 1'b1;
                rr_win = scan[PW-1:0];
            end
        end
    end

`ifdef FFRE_SCHED_PRIO_EN
    // Priority search: lowest index with both req and prio set.
    always_comb begin
        pr_hit = 1'b0;
        pr_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k] && prio[k]) begin
                pr_hit = 1'b1;
                pr_win = PW'(k);
            end
        end
    end
`else
    // Without the priority option nothing ever overrides round robin.
    always_comb begin
        pr_hit = 1'b0;
        pr_win = '0;
    end
`endif

    // Final winner selection and the pointer value that follows a round-robin grant.
    always_comb begin
        win     = pr_hit ? pr_win : rr_win;
        ptr_nxt = (rr_win == PW'(NREQ - 1)) ? '0 : (rr_win + PW'(1));
    end

    // Scheduler FSM; every output is a register written alongside the state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win_q   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            ena     <= '0;
            grp_clr <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done    <= '0;
                    grp_clr <= '0;
                    ena     <= '0;
                    if (|req) begin
                        win_q <= win;
                        gnt   <= onehot(win);
                        busy  <= 1'b1;
                        // A priority grant must not disturb the round-robin order.
                        if (!pr_hit) begin
                            ptr <= ptr_nxt;
                        end
                        if (clr_req[win]) begin
                            state   <= S_CLEAR;
                            grp_clr <= onehot(win);
                        end else begin
                            state <= S_LOAD;
                            ena   <= onehot(win);
                            cnt   <= BURST_LD;
                        end
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end

                S_CLEAR: begin
                    // The clear pulse lasts exactly one cycle, then the burst starts.
                    grp_clr <= '0;
                    ena     <= onehot(win_q);
                    cnt     <= BURST_LD;
                    state   <= S_LOAD;
                end

                S_LOAD: begin
                    if (cnt == '0) begin
                        gnt  <= '0;
                        ena  <= '0;
                        done <= onehot(win_q);
                        if (GAP > 0) begin
                            state <= S_GAP;
                            cnt   <= GAP_LD;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_GAP: begin
                    // done only marks the first gap cycle.
                    done <= '0;
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    gnt     <= '0;
                    ena     <= '0;
                    grp_clr <= '0;
                    done    <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffre_ena_sched.sv
// Self-checking bench for ffre_ena_sched.
// Instance a: NREQ=5, BURST=4, GAP=1. Instance b: NREQ=5, BURST=1, GAP=0.
// Vectors name group indices explicitly (oh(i) sets bit i of a [0:4] vector).
module tb_ffre_ena_sched;

    localparam int N = 5;
    localparam logic [0:N-1] Z = '0;

    logic         clk = 1'b0;
    logic         clr;
    logic [0:N-1] req_a, clr_req_a, gnt_a, ena_a, grp_clr_a, done_a;
    logic         busy_a;
    logic [1:0]   st_a;
    logic [0:N-1] req_b, clr_req_b, gnt_b, ena_b, grp_clr_b, done_b;
    logic         busy_b;
    logic [1:0]   st_b;
`ifdef FFRE_SCHED_PRIO_EN
    logic [0:N-1] prio_a, prio_b;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:N-1] req;
        logic [0:N-1] clr_req;
        logic [0:N-1] gnt;
        logic [0:N-1] ena;
        logic [0:N-1] grp_clr;
        logic [0:N-1] done;
        logic         busy;
    } vec_t;

    vec_t tbl[20];

    ffre_ena_sched #(.NREQ(N), .BURST(4), .GAP(1), .CW(8)) u_dut_a (
        .clk(clk), .clr(clr), .req(req_a), .clr_req(clr_req_a),
`ifdef FFRE_SCHED_PRIO_EN
        .prio(prio_a),
`endif
        .gnt(gnt_a), .ena(ena_a), .grp_clr(grp_clr_a), .done(done_a),
        .busy(busy_a), .dbg_state(st_a)
    );

    ffre_ena_sched #(.NREQ(N), .BURST(1), .GAP(0), .CW(8)) u_dut_b (
        .clk(clk), .clr(clr), .req(req_b), .clr_req(clr_req_b),
`ifdef FFRE_SCHED_PRIO_EN
        .prio(prio_b),
`endif
        .gnt(gnt_b), .ena(ena_b), .grp_clr(grp_clr_b), .done(done_b),
        .busy(busy_b), .dbg_state(st_b)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    function automatic logic [0:N-1] oh(input int i);
        logic [0:N-1] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(input logic [0:N-1] r, input logic [0:N-1] cr,
                                input logic [0:N-1] g, input logic [0:N-1] e,
                                input logic [0:N-1] gc, input logic [0:N-1] d,
                                input logic b);
        vec_t v;
        v.req = r; v.clr_req = cr; v.gnt = g; v.ena = e;
        v.grp_clr = gc; v.done = d; v.busy = b;
        return v;
    endfunction

    task automatic chk_v(input string name, input logic [0:N-1] act, input logic [0:N-1] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, budget, e;
        bit ok;

        // ---------------- vector table: single request, re-grant, clear path ----------------
        tbl[0]  = mk(oh(2), Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[1]  = mk(oh(2), Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[2]  = mk(oh(2), Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[3]  = mk(oh(2), Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[4]  = mk(oh(2), Z, Z, Z, Z, oh(2), 1'b1);
        tbl[5]  = mk(oh(2), Z, Z, Z, Z, Z, 1'b0);
        tbl[6]  = mk(oh(2), Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[7]  = mk(Z, Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[8]  = mk(Z, Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[9]  = mk(Z, Z, oh(2), oh(2), Z, Z, 1'b1);
        tbl[10] = mk(Z, Z, Z, Z, Z, oh(2), 1'b1);
        tbl[11] = mk(Z, Z, Z, Z, Z, Z, 1'b0);
        tbl[12] = mk(oh(3), oh(3), oh(3), Z, oh(3), Z, 1'b1);
        tbl[13] = mk(Z, Z, oh(3), oh(3), Z, Z, 1'b1);
        tbl[14] = mk(oh(0), oh(0), oh(3), oh(3), Z, Z, 1'b1);
        tbl[15] = mk(oh(0), oh(0), oh(3), oh(3), Z, Z, 1'b1);
        tbl[16] = mk(oh(0), oh(0), oh(3), oh(3), Z, Z, 1'b1);
        tbl[17] = mk(oh(0), oh(0), Z, Z, Z, oh(3), 1'b1);
        tbl[18] = mk(Z, Z, Z, Z, Z, Z, 1'b0);
        tbl[19] = mk(Z, Z, Z, Z, Z, Z, 1'b0);

        // ---------------- reset ----------------
        clr = 1'b1;
        req_a = Z; clr_req_a = Z; req_b = Z; clr_req_b = Z;
`ifdef FFRE_SCHED_PRIO_EN
        prio_a = Z; prio_b = Z;
`endif
        step();
        step();
        chk_v("rst_gnt", gnt_a, Z);
        chk_v("rst_ena", ena_a, Z);
        chk_v("rst_grp_clr", grp_clr_a, Z);
        chk_v("rst_done", done_a, Z);
        chk_i("rst_busy", int'(busy_a), 0);
        chk_i("rst_state", int'(st_a), 0);
        chk_v("rst_gnt_b", gnt_b, Z);
        clr = 1'b0;
        step();

        // ---------------- table-driven section ----------------
        for (int i = 0; i < 20; i++) begin
            req_a     = tbl[i].req;
            clr_req_a = tbl[i].clr_req;
            step();
            chk_v($sformatf("tbl%0d_gnt", i), gnt_a, tbl[i].gnt);
            chk_v($sformatf("tbl%0d_ena", i), ena_a, tbl[i].ena);
            chk_v($sformatf("tbl%0d_grp_clr", i), grp_clr_a, tbl[i].grp_clr);
            chk_v($sformatf("tbl%0d_done", i), done_a, tbl[i].done);
            chk_i($sformatf("tbl%0d_busy", i), int'(busy_a), int'(tbl[i].busy));
        end

        // ---------------- reset mid-LOAD, then pointer back to 0 ----------------
        // Pointer sits at 4 here; a grant to group 0 moves it to 1.
        req_a = oh(0);
        step();
        chk_v("mid_first_gnt", gnt_a, oh(0));
        step();
        chk_v("mid_loading", ena_a, oh(0));
        #2 clr = 1'b1;
        #1;
        chk_v("mid_rst_gnt", gnt_a, Z);
        chk_v("mid_rst_ena", ena_a, Z);
        chk_v("mid_rst_grp_clr", grp_clr_a, Z);
        chk_v("mid_rst_done", done_a, Z);
        chk_i("mid_rst_busy", int'(busy_a), 0);
        @(negedge clk);
        clr = 1'b0;
        req_a = '1;
        step();
        chk_v("after_rst_ena", ena_a, oh(0));

        // ---------------- fairness with all requests held ----------------
        for (int g = 0; g < 6; g++) begin
            e = g % N;
            chk_v($sformatf("fair%0d_gnt", g), gnt_a, oh(e));
            n = 0; ok = 1'b1; budget = 0;
            while (ena_a !== Z && budget < 20) begin
                if (ena_a !== oh(e) || gnt_a !== oh(e)) ok = 1'b0;
                n++;
                budget++;
                step();
            end
            chk_i($sformatf("fair%0d_len", g), n, 4);
            chk_v($sformatf("fair%0d_done", g), done_a, oh(e));
            chk_i($sformatf("fair%0d_onehot", g), int'(ok), 1);
            if (g == 5) begin
                req_a = Z;
            end else begin
                budget = 0;
                while (gnt_a === Z && budget < 10) begin
                    budget++;
                    step();
                end
            end
        end
        step();
        step();
        chk_i("fair_end_busy", int'(busy_a), 0);
        chk_v("fair_end_gnt", gnt_a, Z);

        // ---------------- BURST=1, GAP=0 boundary on instance b ----------------
        req_b = oh(0) | oh(1);
        step();
        chk_v("b1_gnt", gnt_b, oh(0));
        chk_v("b1_ena", ena_b, oh(0));
        step();
        chk_v("b2_ena", ena_b, Z);
        chk_v("b2_done", done_b, oh(0));
        chk_i("b2_busy", int'(busy_b), 0);
        step();
        chk_v("b3_gnt", gnt_b, oh(1));
        chk_v("b3_ena", ena_b, oh(1));
        step();
        chk_v("b4_done", done_b, oh(1));
        chk_v("b4_gnt", gnt_b, Z);
        step();
        chk_v("b5_gnt", gnt_b, oh(0));
        req_b = Z;
        step();
        chk_v("b6_done", done_b, oh(0));
        step();
        chk_v("b7_gnt", gnt_b, Z);
        chk_i("b7_busy", int'(busy_b), 0);

`ifdef FFRE_SCHED_PRIO_EN
        // ---------------- priority grant leaves the pointer alone ----------------
        // Pointer is 1 after fairness; a grant to group 1 moves it to 2.
        req_a = oh(1);
        step();
        chk_v("p_setup_gnt", gnt_a, oh(1));
        req_a = Z;
        for (int i = 0; i < 6; i++) step();
        req_a = oh(0) | oh(2);
        prio_a = oh(0);
        step();
        chk_v("p_prio_gnt", gnt_a, oh(0));
        req_a = oh(1) | oh(2);
        prio_a = Z;
        for (int i = 0; i < 6; i++) step();
        step();
        chk_v("p_rr_gnt", gnt_a, oh(2));
        req_a = Z;
        for (int i = 0; i < 8; i++) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
